// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its next-PC logic.
package instr_fetch_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned IMM_W         = 16;
    localparam int unsigned ADDR26_W      = 26;
    localparam int unsigned BR_SHIFT      = 2;
    localparam int unsigned JUMP_REGION_W = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = XLEN'(32'h0000_0000);
    localparam logic [XLEN-1:0] INSTR_BYTES      = XLEN'(4);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

    // Word offset to byte offset: sign-extend to XLEN, then scale by 4.
    function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
        return XLEN'({{(XLEN-IMM_W){imm[IMM_W-1]}}, imm}) << BR_SHIFT;
    endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC selection: jump, taken branch, or sequential.
module next_pc_calc
    import instr_fetch_pkg::*;
(
    input  logic [XLEN-1:0]     pc_plus4,
    input  logic                is_jump,
    input  logic                is_branch,
    input  logic                branch_taken,
    input  logic [IMM_W-1:0]    imm16,
    input  logic [ADDR26_W-1:0] addr26,
    output logic [XLEN-1:0]     next_pc_c
);

    // Jump wins over branch; all targets stay word-aligned by construction.
    always_comb begin
        next_pc_c = pc_plus4;
        if (is_jump) begin
            next_pc_c = {pc_plus4[XLEN-1:XLEN-JUMP_REGION_W], addr26, 2'b00};
        end else if (is_branch && branch_taken) begin
            next_pc_c = pc_plus4 + branch_offset(imm16);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests a word at pc, holds it for the decoder until
// the datapath retires it, then advances pc and the retire counter.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [XLEN-1:0]     imem_addr,
    input  logic                imem_ack,
    input  logic [XLEN-1:0]     imem_rdata,
    output logic [XLEN-1:0]     instruction,
    output logic                instr_valid,
    input  logic                instr_done,
    input  logic                is_jump,
    input  logic                is_branch,
    input  logic                branch_taken,
    input  logic [IMM_W-1:0]    imm16,
    input  logic [ADDR26_W-1:0] addr26,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic [XLEN-1:0]     instr_count
);

    localparam logic [XLEN-1:0] PC_INIT = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic            accept_c;
    logic            retire_c;
    logic [XLEN-1:0] next_pc_c;

    next_pc_calc u_next_pc (
        .pc_plus4     (pc_plus4),
        .is_jump      (is_jump),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .addr26       (addr26),
        .next_pc_c    (next_pc_c)
    );

    // An ack only counts while the request is actually visible, so a read
    // issued before reset can never land once reset has been applied.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        retire_c   = 1'b0;
        case (state)
            FETCH: begin
                if (imem_req && imem_ack) begin
                    accept_c   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_done) begin
                    retire_c   = 1'b1;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instruction <= XLEN'(0);
            pc          <= PC_INIT;
            pc_plus4    <= PC_INIT + INSTR_BYTES;
            instr_count <= XLEN'(0);
        end else begin
            state       <= state_next;
            imem_req    <= (state_next == FETCH);
            instr_valid <= (state_next == ISSUE);
            if (accept_c) begin
                instruction <= imem_rdata;
            end
            if (retire_c) begin
                pc          <= next_pc_c;
                pc_plus4    <= next_pc_c + INSTR_BYTES;
                instr_count <= instr_count + XLEN'(1);
            end
        end
    end

    assign imem_addr = pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_done = 1'b0;
    logic        is_jump = 1'b0;
    logic        is_branch = 1'b0;
    logic        branch_taken = 1'b0;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] addr26 = 26'h0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: out-of-reset flag, held-word flag, pc, word, retire count.
    logic        m_live = 1'b0;
    logic        m_have = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_count = 32'h0;

    instr_fetch dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .instr_done   (instr_done),
        .is_jump      (is_jump),
        .is_branch    (is_branch),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .addr26       (addr26),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic j,
                                             input logic b, input logic t,
                                             input logic [15:0] im, input logic [25:0] ad);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (j) return (seq & 32'hF000_0000) | (32'(ad) * 32'd4);
        if (b && t) return seq + 32'($signed(im)) * 32'd4;
        return seq;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_live  = 1'b0;
            m_have  = 1'b0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_count = 32'h0;
        end else begin
            if (m_live && !m_have && imem_ack) begin
                m_instr = imem_rdata;
                m_have  = 1'b1;
            end else if (m_have && instr_done) begin
                m_pc    = ref_next(m_pc, is_jump, is_branch, branch_taken, imm16, addr26);
                m_count = m_count + 32'd1;
                m_have  = 1'b0;
            end
            m_live = 1'b1;
        end
    endtask

    task automatic compare_all();
        check("imem_req", 32'(imem_req), 32'(m_live && !m_have));
        check("instr_valid", 32'(instr_valid), 32'(m_live && m_have));
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("instruction", instruction, m_instr);
        check("instr_count", instr_count, m_count);
        if (m_live && !m_have) check("imem_addr", imem_addr, m_pc);
    endtask

    // Apply one cycle of inputs (from a negedge), clock it, then check at the negedge.
    task automatic step(input logic r, input logic a, input logic [31:0] rd, input logic d,
                        input logic j, input logic b, input logic t,
                        input logic [15:0] im, input logic [25:0] ad);
        reset = r; imem_ack = a; imem_rdata = rd; instr_done = d;
        is_jump = j; is_branch = b; branch_taken = t; imm16 = im; addr26 = ad;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic fetch(input logic [31:0] rd);
        step(1'b0, 1'b1, rd, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    endtask

    task automatic retire(input logic j, input logic b, input logic t,
                          input logic [15:0] im, input logic [25:0] ad);
        step(1'b0, 1'b0, $urandom, 1'b1, j, b, t, im, ad);
    endtask

    initial begin
        logic [31:0] base;

        @(negedge clk);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc", pc, 32'h0);

        // First fetch after reset, ack in the first request cycle
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        fetch(32'h2010_FEFE);
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_instr", instruction, 32'h2010_FEFE);
        check("first_pc", pc, 32'h0);

        // Branch taken / not taken from 0x10
        retire(1'b0 | 1'b1, 1'b0, 1'b0, 16'h0, 26'h4);
        check("jump_to_10", imem_addr, 32'h10);
        fetch($urandom);
        retire(1'b0, 1'b1, 1'b1, 16'hFFFD, 26'h0);
        check("br_taken", imem_addr, 32'h08);
        fetch($urandom);
        retire(1'b1, 1'b0, 1'b0, 16'h0, 26'h4);
        fetch($urandom);
        retire(1'b0, 1'b1, 1'b0, 16'hFFFD, 26'h0);
        check("br_not_taken", imem_addr, 32'h14);

        // Jump beats branch
        fetch($urandom);
        retire(1'b1, 1'b0, 1'b0, 16'h0, 26'h8);
        check("jump_to_20", imem_addr, 32'h20);
        fetch($urandom);
        retire(1'b1, 1'b1, 1'b1, 16'h0010, 26'h40);
        check("jump_prio", imem_addr, 32'h100);

        // Walk to the top of the address space, then wrap
        fetch($urandom);
        retire(1'b0, 1'b1, 1'b1, 16'h8000, 26'h0);
        check("br_negmax", imem_addr, 32'hFFFE_0104);
        fetch($urandom);
        retire(1'b1, 1'b0, 1'b0, 16'h0, 26'h3FF_FFFF);
        check("jump_top", pc, 32'hFFFF_FFFC);
        fetch($urandom);
        check("wrap_plus4", pc_plus4, 32'h0);
        base = m_count;
        retire(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_count", instr_count, base + 32'd1);

        // Reset during a pending fetch, then the late ack
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check("rstmid_req", 32'(imem_req), 32'd0);
        check("rstmid_instr", instruction, 32'h0);
        check("rstmid_count", instr_count, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check("refetch_addr", imem_addr, 32'h0);
        check("refetch_instr", instruction, 32'h0);
        fetch(32'h1234_5678);
        check("late_ack_instr", instruction, 32'h1234_5678);

        // instr_done and ack held high: one retire per issued word
        base = m_count;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        end
        check("held_done_count", instr_count, base + 32'd3);
        check("held_done_pc", pc, 32'h0C);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 16'($urandom), 26'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
